maze_map: RTL and testbench
===========================

Name: maze_map

Overview:
- Playfield responder on the other end of the pacman controller's next-tile/wall interface.
- Answers wall queries for the next tile the controller wants to enter.
- Owns a 32x32 pellet store. Pellets are eaten when pacman occupies a tile, and the block keeps score, pellets remaining and level-clear status.
- Drives the background colour (walls, pellets) for the video mixer, aligned to the pacman sprite screen mapping.

Parameters:
- BORDER_MIN, 1: tiles with x or y <= this are wall.
- BORDER_MAX, 28: tiles with x or y >= this are wall.
- PELLET_POINTS, 10: score added per pellet eaten.
- SCREEN_OFFSET, 20: pixel offset between tile grid and screen (screen = tile*8 - offset).
- WALL_COLOR, 3'b001: col value for wall pixels.
- PELLET_COLOR, 3'b110: col value for pellet dot pixels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- qx  in  5  query tile x (controller's next x)
- qy  in  5  query tile y (controller's next y)
- map_wall  out  1  1 = queried tile is wall
- pac_x  in  5  pacman current tile x
- pac_y  in  5  pacman current tile y
- eat_stb  in  1  one-cycle strobe: pacman occupies (pac_x, pac_y)
- restart  in  1  one-cycle strobe: refill pellets, start new level
- shpos  in  10  video horizontal position
- svpos  in  10  video vertical position
- col  out  3  background colour
- score  out  14  accumulated score
- pellets_left  out  10  pellets remaining
- level_clear  out  1  high while in CLEAR state

Behaviour:
- Wall function, combinational: wall(x,y) = x<=BORDER_MIN | x>=BORDER_MAX | y<=BORDER_MIN | y>=BORDER_MAX | (x[1:0]==0 & y[1:0]==0).
- map_wall is registered, latency 1 clk: map_wall <= wall(qx,qy) every cycle in all states.
- Pellet store: 1024 bits, address {y,x}.
- Reset values: FSM=FILL, fill address 0, map_wall 0, col 0, score 0, pellets_left 0, level_clear 0.

FSM states FILL, RUN, CLEAR:
- FILL:
  - Each cycle, write pellet[addr] = ~wall(addr[4:0], addr[9:5]).
  - If a pellet was written, pellets_left += 1.
  - addr += 1. After addr 1023 is written, go to RUN.
  - Duration is exactly 1024 cycles, and pellets_left ends at 640 with default parameters.
  - eat_stb is ignored.
  - Entry from restart clears pellets_left to 0 and addr to 0 in the same edge.
  - restart during FILL restarts the sweep from addr 0 with pellets_left 0.
- RUN:
  - On eat_stb with pellet[{pac_y,pac_x}]==1: clear that bit, score += PELLET_POINTS saturating at 16383, pellets_left -= 1.
  - If pellets_left transitions 1->0, go to CLEAR in the same edge.
  - eat_stb on an empty or wall tile has no effect.
  - restart goes to FILL.
  - If restart and eat_stb arrive together, restart wins and no points are awarded.
- CLEAR:
  - level_clear = 1 and eat_stb is ignored.
  - restart goes to FILL, with level_clear = 0 from the next cycle.
- score is cleared only by rst_n; it persists across restart.
- rst_n asserted mid-FILL or mid-RUN returns immediately to reset values. Pellet store contents are don't-care until the next FILL completes.

Video path:
- sx = shpos + SCREEN_OFFSET and sy = svpos + SCREEN_OFFSET, 10-bit wrap.
- If sx[9:8]!=0 or sy[9:8]!=0, the pixel is off-map and col gets 0.
- Otherwise tile = (sx[7:3], sy[7:3]).
- Colour priority:
  - WALL_COLOR if the tile is wall.
  - Else PELLET_COLOR if state!=FILL, pellet bit set, sx[2:0] in {3,4} and sy[2:0] in {3,4}.
  - Else 0.
- col is registered, latency 1 clk.

Test Plan:
- Reset, then hold 1024 cycles -> pellets_left counts 0..640, RUN entered at cycle 1024, level_clear 0, score 0.
- Query qx=1,qy=5 / qx=4,qy=8 / qx=2,qy=2 -> map_wall 1 / 1 / 0, each one cycle after the query is applied.
- RUN, eat_stb at (2,2) twice -> score 10, pellets_left 639 after first; second strobe leaves both unchanged. eat_stb at (4,4) pillar -> no change.
- Force pellets_left path to 1 and eat the last pellet -> pellets_left 0, level_clear 1 next cycle. Further eat_stb ignored. restart -> FILL, pellets_left climbs back to 640, score retained.
- restart and eat_stb same cycle on a pellet tile in RUN -> score unchanged, FSM FILL. rst_n pulse mid-FILL (addr 500) -> all outputs 0, sweep restarts from 0.
- Video at shpos=0,svpos=0 (tile 2,2, sub 4,4) -> col 3'b110 one cycle later. After eating (2,2) -> col 0. shpos=0,svpos=20 (tile 2,5, sub 4,0) -> col 0. shpos=300 (sx[9:8]!=0) -> col 0.

Source files
------------

// File: rtl/maze_map.sv
// maze_map: playfield responder for the pacman controller.
//
// Answers wall queries for the tile the controller wants to enter next,
// owns a 32x32 pellet store that is swept full at the start of every level,
// eats pellets where pacman stands, keeps score / pellets remaining /
// level-clear status, and paints the background (walls and pellet dots)
// for the video mixer using the same screen mapping as the pacman sprite.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   qx, qy      (in  5)   query tile; map_wall (out 1) answers one clock later
//   pac_x, pac_y(in  5)   pacman current tile
//   eat_stb     (in  1)   pacman occupies (pac_x, pac_y) this cycle
//   restart     (in  1)   refill pellets and start a new level
//   shpos, svpos(in 10)   video beam position
//   col         (out 3)   background colour, one clock behind the beam
//   score       (out 14)  accumulated score, saturating, kept across levels
//   pellets_left(out 10)  pellets still on the board
//   level_clear (out 1)   high while the board is empty (CLEAR state)
module maze_map #(
    parameter int unsigned    BORDER_MIN    = 1,
    parameter int unsigned    BORDER_MAX    = 28,
    parameter int unsigned    PELLET_POINTS = 10,
    parameter int unsigned    SCREEN_OFFSET = 20,
    parameter logic [2:0]     WALL_COLOR    = 3'b001,
    parameter logic [2:0]     PELLET_COLOR  = 3'b110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  qx,
    input  logic [4:0]  qy,
    output logic        map_wall,
    input  logic [4:0]  pac_x,
    input  logic [4:0]  pac_y,
    input  logic        eat_stb,
    input  logic        restart,
    input  logic [9:0]  shpos,
    input  logic [9:0]  svpos,
    output logic [2:0]  col,
    output logic [13:0] score,
    output logic [9:0]  pellets_left,
    output logic        level_clear
);

    typedef enum logic [1:0] {FILL, RUN, CLEAR} state_t;

    localparam logic [4:0]  BMIN     = 5'(BORDER_MIN);
    localparam logic [4:0]  BMAX     = 5'(BORDER_MAX);
    localparam logic [14:0] POINTS   = 15'(PELLET_POINTS);
    localparam logic [9:0]  SOFF     = 10'(SCREEN_OFFSET);
    localparam logic [14:0] SCORE_MAX = 15'd16383;

    state_t        state;
    logic [9:0]    fill_addr;
    logic [1023:0] pellet;

    // Border ring plus a pillar on every tile whose x and y are both multiples of 4.
    function automatic logic is_wall(input logic [4:0] x, input logic [4:0] y);
        return (x <= BMIN) || (x >= BMAX) || (y <= BMIN) || (y >= BMAX) ||
               ((x[1:0] == 2'b00) && (y[1:0] == 2'b00));
    endfunction

    logic        fill_bit;
    logic [9:0]  eat_addr;
    logic        eat_hit;
    logic [14:0] score_sum;
    logic [13:0] score_next;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [4:0]  tile_x;
    logic [4:0]  tile_y;
    logic        dot_x;
    logic        dot_y;
    logic [2:0]  col_next;

    // Pellet decisions and saturating score update. The store is addressed {y,x}.
    always_comb begin
        fill_bit   = ~is_wall(fill_addr[4:0], fill_addr[9:5]);
        eat_addr   = {pac_y, pac_x};
        eat_hit    = eat_stb && pellet[eat_addr];
        score_sum  = {1'b0, score} + POINTS;
        score_next = (score_sum > SCORE_MAX) ? SCORE_MAX[13:0] : score_sum[13:0];
    end

    // Background colour for the current beam position. Screen coordinates are
    // shifted by the sprite offset and anything beyond 256 pixels is off-map.
    // Pellets are hidden while the store is being swept so a half-filled board
    // never flashes on screen.
    always_comb begin
        sx       = shpos + SOFF;
        sy       = svpos + SOFF;
        tile_x   = sx[7:3];
        tile_y   = sy[7:3];
        dot_x    = (sx[2:0] == 3'd3) || (sx[2:0] == 3'd4);
        dot_y    = (sy[2:0] == 3'd3) || (sy[2:0] == 3'd4);
        col_next = 3'b000;
        if ((sx[9:8] == 2'b00) && (sy[9:8] == 2'b00)) begin
            if (is_wall(tile_x, tile_y))
                col_next = WALL_COLOR;
            else if ((state != FILL) && pellet[{tile_y, tile_x}] && dot_x && dot_y)
                col_next = PELLET_COLOR;
        end
    end

    // Pellet store. Deliberately not reset: its contents only matter once a
    // full sweep has rewritten every bit, and the sweep happens after reset.
    always_ff @(posedge clk) begin
        if (state == FILL)
            pellet[fill_addr] <= fill_bit;
        else if ((state == RUN) && eat_hit && !restart)
            pellet[eat_addr] <= 1'b0;
    end

    // Level FSM with registered outputs. restart always takes priority over
    // eating, and score survives restart so it accumulates across levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL;
            fill_addr    <= '0;
            map_wall     <= 1'b0;
            col          <= '0;
            score        <= '0;
            pellets_left <= '0;
            level_clear  <= 1'b0;
        end else begin
            map_wall <= is_wall(qx, qy);
            col      <= col_next;
            case (state)
                FILL: begin
                    if (restart) begin
                        fill_addr    <= '0;
                        pellets_left <= '0;
                    end else begin
                        if (fill_bit)
                            pellets_left <= pellets_left + 10'd1;
                        fill_addr <= fill_addr + 10'd1;
                        if (fill_addr == 10'd1023)
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (restart) begin
                        state        <= FILL;
                        fill_addr    <= '0;
                        pellets_left <= '0;
                    end else if (eat_hit) begin
                        score        <= score_next;
                        pellets_left <= pellets_left - 10'd1;
                        if (pellets_left == 10'd1) begin
                            state       <= CLEAR;
                            level_clear <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (restart) begin
                        state        <= FILL;
                        fill_addr    <= '0;
                        pellets_left <= '0;
                        level_clear  <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_map.sv
// tb_maze_map: directed, self-checking bench for maze_map.
// A table of query/video vectors with hand-computed answers is run once the
// board is full, followed by hand-written sequences for fill timing, eating,
// level clear, restart priority and asynchronous reset mid-sweep.
module tb_maze_map;

    logic        clk;
    logic        rst_n;
    logic [4:0]  qx;
    logic [4:0]  qy;
    logic        map_wall;
    logic [4:0]  pac_x;
    logic [4:0]  pac_y;
    logic        eat_stb;
    logic        restart;
    logic [9:0]  shpos;
    logic [9:0]  svpos;
    logic [2:0]  col;
    logic [13:0] score;
    logic [9:0]  pellets_left;
    logic        level_clear;

    int total;
    int bad;

    typedef struct {
        logic [4:0] vqx;
        logic [4:0] vqy;
        logic [9:0] vh;
        logic [9:0] vv;
        logic       exp_wall;
        logic [2:0] exp_col;
    } vec_t;

    vec_t vecs[10];

    maze_map dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .qx          (qx),
        .qy          (qy),
        .map_wall    (map_wall),
        .pac_x       (pac_x),
        .pac_y       (pac_y),
        .eat_stb     (eat_stb),
        .restart     (restart),
        .shpos       (shpos),
        .svpos       (svpos),
        .col         (col),
        .score       (score),
        .pellets_left(pellets_left),
        .level_clear (level_clear)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one table vector, let one edge register it, then compare.
    task automatic applyStimulus(input vec_t v, input int idx);
        qx    = v.vqx;
        qy    = v.vqy;
        shpos = v.vh;
        svpos = v.vv;
        tick(1);
        checkOutput($sformatf("vec%0d map_wall", idx), int'(map_wall), int'(v.exp_wall));
        checkOutput($sformatf("vec%0d col", idx), int'(col), int'(v.exp_col));
    endtask

    task automatic eatAt(input int x, input int y);
        pac_x   = 5'(x);
        pac_y   = 5'(y);
        eat_stb = 1'b1;
        tick(1);
        eat_stb = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        qx      = '0;
        qy      = '0;
        pac_x   = '0;
        pac_y   = '0;
        eat_stb = 1'b0;
        restart = 1'b0;
        shpos   = '0;
        svpos   = '0;

        // Query and video vectors: tile = (pos + 20) / 8, sub-pixel = (pos + 20) % 8.
        vecs[0] = '{5'd1,  5'd5,  10'd0,    10'd0,   1'b1, 3'b110}; // tile(2,2) sub(4,4) dot
        vecs[1] = '{5'd4,  5'd8,  10'd0,    10'd20,  1'b1, 3'b000}; // tile(2,5) sub(4,0)
        vecs[2] = '{5'd2,  5'd2,  10'd300,  10'd0,   1'b0, 3'b000}; // off-map x
        vecs[3] = '{5'd0,  5'd0,  10'd0,    10'd0,   1'b1, 3'b110};
        vecs[4] = '{5'd27, 5'd27, 10'd1016, 10'd0,   1'b0, 3'b001}; // sx wraps to 12 -> tile(1,2)
        vecs[5] = '{5'd27, 5'd10, 10'd12,   10'd12,  1'b0, 3'b001}; // pillar tile(4,4)
        vecs[6] = '{5'd28, 5'd10, 10'd3,    10'd3,   1'b1, 3'b000}; // sub(7,7) no dot
        vecs[7] = '{5'd10, 5'd28, 10'd1023, 10'd0,   1'b1, 3'b110}; // sub(3,4) dot
        vecs[8] = '{5'd2,  5'd27, 10'd0,    10'd235, 1'b0, 3'b001}; // tile(2,31) border
        vecs[9] = '{5'd8,  5'd12, 10'd236,  10'd0,   1'b1, 3'b000}; // sx=256 off-map

        #22;
        checkOutput("reset map_wall", int'(map_wall), 0);
        checkOutput("reset col", int'(col), 0);
        checkOutput("reset score", int'(score), 0);
        checkOutput("reset pellets_left", int'(pellets_left), 0);
        checkOutput("reset level_clear", int'(level_clear), 0);
        rst_n = 1'b1;

        // Fill sweep: rows 0,1 wall, row 2 has 26 pellets, row 3 x=2,3 -> 28 by addr 99.
        tick(100);
        checkOutput("fill100 pellets_left", int'(pellets_left), 28);
        checkOutput("fill100 col hidden", int'(col), 0);
        tick(924);
        checkOutput("fill1024 pellets_left", int'(pellets_left), 640);
        checkOutput("fill1024 col still fill", int'(col), 0);
        checkOutput("fill1024 level_clear", int'(level_clear), 0);
        checkOutput("fill1024 score", int'(score), 0);
        tick(1);
        checkOutput("run entry col dot", int'(col), 6);

        for (int i = 0; i < 10; i++)
            applyStimulus(vecs[i], i);

        // Eat (2,2) twice, then try a pillar.
        shpos = '0;
        svpos = '0;
        eatAt(2, 2);
        checkOutput("eat1 score", int'(score), 10);
        checkOutput("eat1 pellets_left", int'(pellets_left), 639);
        tick(1);
        checkOutput("eaten dot col", int'(col), 0);
        eatAt(2, 2);
        checkOutput("eat2 score", int'(score), 10);
        checkOutput("eat2 pellets_left", int'(pellets_left), 639);
        eatAt(4, 4);
        checkOutput("pillar score", int'(score), 10);
        checkOutput("pillar pellets_left", int'(pellets_left), 639);

        // Eat every pellet except (27,27), then the last one.
        for (int y = 2; y <= 27; y++) begin
            for (int x = 2; x <= 27; x++) begin
                if ((x % 4 == 0 && y % 4 == 0) || (x == 2 && y == 2) || (x == 27 && y == 27))
                    continue;
                eatAt(x, y);
            end
        end
        checkOutput("last1 pellets_left", int'(pellets_left), 1);
        checkOutput("last1 level_clear", int'(level_clear), 0);
        checkOutput("last1 score", int'(score), 6390);
        eatAt(27, 27);
        checkOutput("clear pellets_left", int'(pellets_left), 0);
        checkOutput("clear level_clear", int'(level_clear), 1);
        checkOutput("clear score", int'(score), 6400);
        eatAt(27, 27);
        checkOutput("clear ignore score", int'(score), 6400);
        checkOutput("clear hold level_clear", int'(level_clear), 1);

        // Restart from CLEAR: refill, score kept.
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        checkOutput("restart level_clear", int'(level_clear), 0);
        checkOutput("restart pellets_left", int'(pellets_left), 0);
        tick(1024);
        checkOutput("refill pellets_left", int'(pellets_left), 640);
        checkOutput("refill score kept", int'(score), 6400);
        tick(1);
        checkOutput("refill col dot", int'(col), 6);

        // restart and eat together on a pellet: restart wins.
        pac_x   = 5'd2;
        pac_y   = 5'd2;
        eat_stb = 1'b1;
        restart = 1'b1;
        tick(1);
        eat_stb = 1'b0;
        restart = 1'b0;
        checkOutput("restart+eat score", int'(score), 6400);
        checkOutput("restart+eat pellets_left", int'(pellets_left), 0);
        tick(1);
        checkOutput("restart+eat col fill", int'(col), 0);

        // Asynchronous reset around fill addr 500.
        tick(499);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset score", int'(score), 0);
        checkOutput("midreset pellets_left", int'(pellets_left), 0);
        checkOutput("midreset col", int'(col), 0);
        checkOutput("midreset map_wall", int'(map_wall), 0);
        checkOutput("midreset level_clear", int'(level_clear), 0);
        #2;
        rst_n = 1'b1;
        tick(100);
        checkOutput("resweep pellets_left", int'(pellets_left), 28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
